// File: rtl/shift_issue_if.sv
// Handshake and data bundle between decode and the shift issue stage.
// The slave side is the issue stage; the master side is decode plus the downstream shifter.
interface shift_issue_if #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5,
    parameter int REG_AW  = 5
);
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [5:0]         in_funct;
    logic [SHAMT_W-1:0] in_shamt;
    logic [REG_AW-1:0]  in_rs_addr;
    logic [DATA_W-1:0]  in_rs_data;
    logic [REG_AW-1:0]  in_rt_addr;
    logic [DATA_W-1:0]  in_rt_data;
    logic [REG_AW-1:0]  in_rd_addr;
    logic               ex_wr_en;
    logic [REG_AW-1:0]  ex_wr_addr;
    logic [DATA_W-1:0]  ex_wr_data;
    logic               wb_wr_en;
    logic [REG_AW-1:0]  wb_wr_addr;
    logic [DATA_W-1:0]  wb_wr_data;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  sh_indata;
    logic [SHAMT_W-1:0] sh_num;
    logic [1:0]         sh_ctr;
    logic [REG_AW-1:0]  out_rd_addr;
    logic               hazard_stall;
    logic               illegal_op;

    modport master (
        output flush, in_valid, in_funct, in_shamt, in_rs_addr, in_rs_data,
               in_rt_addr, in_rt_data, in_rd_addr, ex_wr_en, ex_wr_addr, ex_wr_data,
               wb_wr_en, wb_wr_addr, wb_wr_data, out_ready,
        input  in_ready, out_valid, sh_indata, sh_num, sh_ctr, out_rd_addr,
               hazard_stall, illegal_op
    );

    modport slave (
        input  flush, in_valid, in_funct, in_shamt, in_rs_addr, in_rs_data,
               in_rt_addr, in_rt_data, in_rd_addr, ex_wr_en, ex_wr_addr, ex_wr_data,
               wb_wr_en, wb_wr_addr, wb_wr_data, out_ready,
        output in_ready, out_valid, sh_indata, sh_num, sh_ctr, out_rd_addr,
               hazard_stall, illegal_op
    );
endinterface

// File: rtl/shift_issue_stage.sv
// Issue register for MIPS shift ops feeding the EX shifter (one entry, valid/ready).
// Define SHIFT_FWD_EN to bypass EX/WB results into operands; otherwise RAW hazards stall input.
module shift_issue_stage #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5,
    parameter int REG_AW  = 5
) (
    input  logic         clk,
    input  logic         rst,
    shift_issue_if.slave sif
);

    function automatic logic is_shift_funct(input logic [5:0] funct);
        return (funct[5:3] == 3'b000) && (funct[1:0] != 2'b01);
    endfunction

    // Register 0 is hardwired to zero, so a write to it never counts as a match.
    function automatic logic wr_hit(input logic en, input logic [REG_AW-1:0] waddr,
                                    input logic [REG_AW-1:0] raddr);
        return en && (waddr == raddr) && (raddr != '0);
    endfunction

    logic [DATA_W-1:0]  rt_res;
    logic [SHAMT_W-1:0] rs_amt;
    logic               hazard;

`ifdef SHIFT_FWD_EN
    function automatic logic [DATA_W-1:0] sel_operand(
        input logic [REG_AW-1:0] addr, input logic [DATA_W-1:0] rf_data,
        input logic ex_en, input logic [REG_AW-1:0] ex_addr, input logic [DATA_W-1:0] ex_data,
        input logic wb_en, input logic [REG_AW-1:0] wb_addr, input logic [DATA_W-1:0] wb_data);
        if (wr_hit(ex_en, ex_addr, addr)) return ex_data;
        if (wr_hit(wb_en, wb_addr, addr)) return wb_data;
        return rf_data;
    endfunction

    always_comb begin
        rt_res = sel_operand(sif.in_rt_addr, sif.in_rt_data,
                             sif.ex_wr_en, sif.ex_wr_addr, sif.ex_wr_data,
                             sif.wb_wr_en, sif.wb_wr_addr, sif.wb_wr_data);
        rs_amt = SHAMT_W'(sel_operand(sif.in_rs_addr, sif.in_rs_data,
                                      sif.ex_wr_en, sif.ex_wr_addr, sif.ex_wr_data,
                                      sif.wb_wr_en, sif.wb_wr_addr, sif.wb_wr_data));
        hazard = 1'b0;
    end
`else
    always_comb begin
        rt_res = sif.in_rt_data;
        rs_amt = sif.in_rs_data[SHAMT_W-1:0];
        hazard = sif.in_valid &&
                 (wr_hit(sif.ex_wr_en, sif.ex_wr_addr, sif.in_rt_addr) ||
                  wr_hit(sif.wb_wr_en, sif.wb_wr_addr, sif.in_rt_addr) ||
                  (sif.in_funct[2] &&
                   (wr_hit(sif.ex_wr_en, sif.ex_wr_addr, sif.in_rs_addr) ||
                    wr_hit(sif.wb_wr_en, sif.wb_wr_addr, sif.in_rs_addr))));
    end
`endif

    logic               vld_p0;
    logic               illegal_p0;
    logic [DATA_W-1:0]  indata_p0;
    logic [SHAMT_W-1:0] num_p0;
    logic [1:0]         ctr_p0;
    logic [REG_AW-1:0]  rd_p0;
    logic               ready;
    logic               accept;
    logic               shift_op;

    assign ready    = (~vld_p0 | sif.out_ready) & ~hazard;
    assign accept   = sif.in_valid & ready;
    assign shift_op = is_shift_funct(sif.in_funct);

    // Stage p0: capture decoded shift control and resolved operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0     <= 1'b0;
            illegal_p0 <= 1'b0;
            indata_p0  <= '0;
            num_p0     <= '0;
            ctr_p0     <= 2'b00;
            rd_p0      <= '0;
        end else begin
            illegal_p0 <= ~sif.flush & accept & ~shift_op;
            if (sif.flush) begin
                vld_p0 <= 1'b0;
            end else if (accept && shift_op) begin
                vld_p0    <= 1'b1;
                indata_p0 <= rt_res;
                num_p0    <= sif.in_funct[2] ? rs_amt : sif.in_shamt;
                ctr_p0    <= sif.in_funct[1:0];
                rd_p0     <= sif.in_rd_addr;
            end else if (accept) begin
                vld_p0 <= 1'b0;
            end else if (vld_p0 && sif.out_ready) begin
                vld_p0 <= 1'b0;
            end
        end
    end

    assign sif.in_ready     = ready;
    assign sif.hazard_stall = hazard;
    assign sif.out_valid    = vld_p0;
    assign sif.illegal_op   = illegal_p0;
    assign sif.sh_indata    = indata_p0;
    assign sif.sh_num       = num_p0;
    assign sif.sh_ctr       = ctr_p0;
    assign sif.out_rd_addr  = rd_p0;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Bench for shift_issue_stage: directed vector table, hand sequences, then random
// traffic against an op-level reference model. Honours SHIFT_FWD_EN like the design.
module tb_shift_issue_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shift_issue_if #(.DATA_W(32), .SHAMT_W(5), .REG_AW(5)) bus ();

    shift_issue_stage #(.DATA_W(32), .SHAMT_W(5), .REG_AW(5)) dut (
        .clk(clk),
        .rst(rst),
        .sif(bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush = 0; bus.in_valid = 0; bus.in_funct = 0; bus.in_shamt = 0;
        bus.in_rs_addr = 0; bus.in_rs_data = 0; bus.in_rt_addr = 0; bus.in_rt_data = 0;
        bus.in_rd_addr = 0; bus.ex_wr_en = 0; bus.ex_wr_addr = 0; bus.ex_wr_data = 0;
        bus.wb_wr_en = 0; bus.wb_wr_addr = 0; bus.wb_wr_data = 0; bus.out_ready = 1;
    endtask

    task automatic set_op(input logic [5:0] f, input logic [4:0] sa,
                          input logic [4:0] rsa, input logic [31:0] rsd,
                          input logic [4:0] rta, input logic [31:0] rtd, input logic [4:0] rd);
        bus.in_valid = 1; bus.in_funct = f; bus.in_shamt = sa;
        bus.in_rs_addr = rsa; bus.in_rs_data = rsd;
        bus.in_rt_addr = rta; bus.in_rt_data = rtd; bus.in_rd_addr = rd;
    endtask

    task automatic set_ex(input logic en, input logic [4:0] a, input logic [31:0] d);
        bus.ex_wr_en = en; bus.ex_wr_addr = a; bus.ex_wr_data = d;
    endtask

    task automatic set_wb(input logic en, input logic [4:0] a, input logic [31:0] d);
        bus.wb_wr_en = en; bus.wb_wr_addr = a; bus.wb_wr_data = d;
    endtask

    // ---------------- reference model (op-level) ----------------
    typedef enum {OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV, OP_BAD} op_e;

    function automatic op_e op_of(input logic [5:0] f);
        case (f)
            6'h00: return OP_SLL;
            6'h02: return OP_SRL;
            6'h03: return OP_SRA;
            6'h04: return OP_SLLV;
            6'h06: return OP_SRLV;
            6'h07: return OP_SRAV;
            default: return OP_BAD;
        endcase
    endfunction

    function automatic logic [1:0] dir_of(input op_e op);
        if (op == OP_SRA || op == OP_SRAV) return 2'b11;
        if (op == OP_SRL || op == OP_SRLV) return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit var_amt(input op_e op);
        return op == OP_SLLV || op == OP_SRLV || op == OP_SRAV;
    endfunction

    function automatic bit pending_write(input logic [4:0] a);
        return a != 0 && ((bus.ex_wr_en && bus.ex_wr_addr == a) ||
                          (bus.wb_wr_en && bus.wb_wr_addr == a));
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] rf);
`ifdef SHIFT_FWD_EN
        if (a == 0) return rf;
        if (bus.ex_wr_en && bus.ex_wr_addr == a) return bus.ex_wr_data;
        if (bus.wb_wr_en && bus.wb_wr_addr == a) return bus.wb_wr_data;
`endif
        return rf;
    endfunction

    function automatic bit exp_hazard();
`ifdef SHIFT_FWD_EN
        return 1'b0;
`else
        return bus.in_valid && (pending_write(bus.in_rt_addr) ||
                                (bus.in_funct[2] && pending_write(bus.in_rs_addr)));
`endif
    endfunction

    logic        m_vld = 0, m_ill = 0;
    logic [31:0] m_data = 0;
    logic [4:0]  m_num = 0, m_rd = 0;
    logic [1:0]  m_ctr = 0;

    function automatic bit exp_ready();
        return (!m_vld || bus.out_ready) && !exp_hazard();
    endfunction

    task automatic model_edge();
        bit acc;
        op_e op;
        logic [31:0] rs_v;
        acc  = bus.in_valid && exp_ready();
        op   = op_of(bus.in_funct);
        rs_v = operand(bus.in_rs_addr, bus.in_rs_data);
        m_ill = !bus.flush && acc && op == OP_BAD;
        if (bus.flush) m_vld = 0;
        else if (acc && op != OP_BAD) begin
            m_vld  = 1;
            m_data = operand(bus.in_rt_addr, bus.in_rt_data);
            m_num  = var_amt(op) ? rs_v[4:0] : bus.in_shamt;
            m_ctr  = dir_of(op);
            m_rd   = bus.in_rd_addr;
        end else if (acc) m_vld = 0;
        else if (m_vld && bus.out_ready) m_vld = 0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [5:0]  funct;
        logic [4:0]  shamt;
        logic [31:0] rs_d;
        logic [31:0] rt_d;
        logic [4:0]  rd;
        logic        e_vld;
        logic [31:0] e_data;
        logic [4:0]  e_num;
        logic [1:0]  e_ctr;
        logic        e_ill;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [5:0] pool[10];
        pool = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h01, 6'h05, 6'h2A};

        vecs[0] = '{6'h00, 5'd4,  32'h12345678, 32'h000000F1, 5'd7,  1'b1, 32'h000000F1, 5'd4,  2'b00, 1'b0};
        vecs[1] = '{6'h07, 5'd9,  32'h00000023, 32'h80000000, 5'd8,  1'b1, 32'h80000000, 5'd3,  2'b11, 1'b0};
        vecs[2] = '{6'h02, 5'd31, 32'h00000000, 32'hDEADBEEF, 5'd9,  1'b1, 32'hDEADBEEF, 5'd31, 2'b10, 1'b0};
        vecs[3] = '{6'h03, 5'd0,  32'h0000001F, 32'h7FFFFFFF, 5'd10, 1'b1, 32'h7FFFFFFF, 5'd0,  2'b11, 1'b0};
        vecs[4] = '{6'h04, 5'd2,  32'hFFFFFFFF, 32'h00000001, 5'd11, 1'b1, 32'h00000001, 5'd31, 2'b00, 1'b0};
        vecs[5] = '{6'h06, 5'd5,  32'h00000020, 32'hCAFEF00D, 5'd12, 1'b1, 32'hCAFEF00D, 5'd0,  2'b10, 1'b0};
        vecs[6] = '{6'h20, 5'd1,  32'h00000001, 32'h00000002, 5'd13, 1'b0, 32'h0,        5'd0,  2'b00, 1'b1};
        vecs[7] = '{6'h01, 5'd1,  32'h00000001, 32'h00000002, 5'd14, 1'b0, 32'h0,        5'd0,  2'b00, 1'b1};
        vecs[8] = '{6'h05, 5'd1,  32'h00000001, 32'h00000002, 5'd15, 1'b0, 32'h0,        5'd0,  2'b00, 1'b1};

        idle();
        nxt(); nxt();
        chk("reset out_valid", bus.out_valid, 0);
        chk("reset sh_indata", bus.sh_indata, 0);
        chk("reset sh_num", bus.sh_num, 0);
        chk("reset sh_ctr", bus.sh_ctr, 0);
        chk("reset out_rd_addr", bus.out_rd_addr, 0);
        chk("reset illegal_op", bus.illegal_op, 0);
        rst = 0;
        nxt();

        for (int i = 0; i < 9; i++) begin
            set_op(vecs[i].funct, vecs[i].shamt, 5'd3, vecs[i].rs_d, 5'd4, vecs[i].rt_d, vecs[i].rd);
            #1 chk($sformatf("vec%0d in_ready", i), bus.in_ready, 1);
            nxt();
            chk($sformatf("vec%0d out_valid", i), bus.out_valid, vecs[i].e_vld);
            chk($sformatf("vec%0d illegal_op", i), bus.illegal_op, vecs[i].e_ill);
            if (vecs[i].e_vld) begin
                chk($sformatf("vec%0d sh_indata", i), bus.sh_indata, vecs[i].e_data);
                chk($sformatf("vec%0d sh_num", i), bus.sh_num, vecs[i].e_num);
                chk($sformatf("vec%0d sh_ctr", i), bus.sh_ctr, vecs[i].e_ctr);
                chk($sformatf("vec%0d out_rd_addr", i), bus.out_rd_addr, vecs[i].rd);
            end
            bus.in_valid = 0;
            nxt();
            chk($sformatf("vec%0d drained", i), bus.out_valid, 0);
            chk($sformatf("vec%0d illegal pulse", i), bus.illegal_op, 0);
        end

        // Backpressure: held entry stays put until out_ready returns.
        set_op(6'h00, 5'd1, 5'd0, 0, 5'd4, 32'h11, 5'd1);
        nxt();
        chk("bp first valid", bus.out_valid, 1);
        bus.out_ready = 0;
        set_op(6'h02, 5'd2, 5'd0, 0, 5'd4, 32'h22, 5'd2);
        #1 chk("bp in_ready low", bus.in_ready, 0);
        nxt();
        chk("bp held valid", bus.out_valid, 1);
        chk("bp held data", bus.sh_indata, 32'h11);
        chk("bp held num", bus.sh_num, 1);
        nxt();
        chk("bp held data 2", bus.sh_indata, 32'h11);
        bus.out_ready = 1;
        #1 chk("bp in_ready high", bus.in_ready, 1);
        nxt();
        chk("bp new data", bus.sh_indata, 32'h22);
        chk("bp new ctr", bus.sh_ctr, 2'b10);
        chk("bp new rd", bus.out_rd_addr, 2);
        bus.in_valid = 0;
        nxt();
        chk("bp drained", bus.out_valid, 0);

        // Bypass / hazard on a pending write to r5.
        set_op(6'h00, 5'd1, 5'd0, 0, 5'd5, 32'h12345678, 5'd9);
        set_ex(1, 5'd5, 32'hAAAA0000);
        set_wb(1, 5'd5, 32'h11111111);
`ifdef SHIFT_FWD_EN
        #1 chk("fwd hazard", bus.hazard_stall, 0);
        chk("fwd in_ready", bus.in_ready, 1);
        nxt();
        chk("fwd ex beats wb", bus.sh_indata, 32'hAAAA0000);
        set_ex(0, 5'd5, 0);
        nxt();
        chk("fwd wb only", bus.sh_indata, 32'h11111111);
        bus.in_rt_addr = 0;
        set_ex(1, 5'd0, 32'hDEAD0000);
        nxt();
        chk("fwd r0 not bypassed", bus.sh_indata, 32'h12345678);
        set_op(6'h07, 5'd0, 5'd6, 32'h0, 5'd0, 32'h80000000, 5'd9);
        set_ex(1, 5'd6, 32'h0000001D);
        set_wb(0, 5'd0, 0);
        nxt();
        chk("fwd rs amount", bus.sh_num, 29);
`else
        #1 chk("stall hazard", bus.hazard_stall, 1);
        chk("stall in_ready", bus.in_ready, 0);
        nxt();
        chk("stall nothing loaded", bus.out_valid, 0);
        set_ex(0, 5'd5, 0);
        #1 chk("stall wb hazard", bus.hazard_stall, 1);
        nxt();
        set_wb(0, 5'd5, 0);
        #1 chk("stall cleared", bus.hazard_stall, 0);
        chk("stall ready", bus.in_ready, 1);
        nxt();
        chk("stall then load", bus.out_valid, 1);
        chk("stall regfile data", bus.sh_indata, 32'h12345678);
        set_op(6'h00, 5'd1, 5'd5, 0, 5'd0, 32'h1, 5'd9);
        set_ex(1, 5'd5, 0);
        #1 chk("sll ignores rs", bus.hazard_stall, 0);
        bus.in_funct = 6'h06;
        #1 chk("srlv rs hazard", bus.hazard_stall, 1);
`endif
        idle();
        nxt();

        // Flush kills an accept and a held entry.
        set_op(6'h00, 5'd3, 5'd0, 0, 5'd4, 32'h55, 5'd3);
        nxt();
        set_op(6'h02, 5'd3, 5'd0, 0, 5'd4, 32'h66, 5'd3);
        bus.flush = 1;
        nxt();
        chk("flush accept out_valid", bus.out_valid, 0);
        bus.flush = 0;
        nxt();
        bus.out_ready = 0;
        bus.in_valid = 0;
        nxt();
        chk("flush held pre", bus.out_valid, 1);
        bus.flush = 1;
        bus.in_valid = 1;
        nxt();
        chk("flush held out_valid", bus.out_valid, 0);
        idle();

        // Asynchronous reset mid-operation.
        set_op(6'h03, 5'd7, 5'd0, 0, 5'd4, 32'h77, 5'd6);
        nxt();
        bus.in_valid = 0;
        bus.out_ready = 0;
        nxt();
        chk("arst pre valid", bus.out_valid, 1);
        rst = 1;
        #1 chk("arst out_valid", bus.out_valid, 0);
        chk("arst sh_indata", bus.sh_indata, 0);
        chk("arst sh_num", bus.sh_num, 0);
        chk("arst sh_ctr", bus.sh_ctr, 0);
        chk("arst rd", bus.out_rd_addr, 0);
        nxt();
        rst = 0;
        idle();
        m_vld = 0; m_ill = 0; m_data = 0; m_num = 0; m_ctr = 0; m_rd = 0;
        nxt();

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            chk("rnd out_valid", bus.out_valid, m_vld);
            chk("rnd illegal_op", bus.illegal_op, m_ill);
            if (m_vld) begin
                chk("rnd sh_indata", bus.sh_indata, m_data);
                chk("rnd sh_num", bus.sh_num, m_num);
                chk("rnd sh_ctr", bus.sh_ctr, m_ctr);
                chk("rnd out_rd_addr", bus.out_rd_addr, m_rd);
            end
            bus.in_valid   = ($urandom_range(0, 3) != 0);
            bus.in_funct   = pool[$urandom_range(0, 9)];
            bus.in_shamt   = 5'($urandom);
            bus.in_rs_addr = 5'($urandom_range(0, 3));
            bus.in_rs_data = $urandom;
            bus.in_rt_addr = 5'($urandom_range(0, 3));
            bus.in_rt_data = $urandom;
            bus.in_rd_addr = 5'($urandom);
            set_ex($urandom_range(0, 3) == 0, 5'($urandom_range(0, 3)), $urandom);
            set_wb($urandom_range(0, 3) == 0, 5'($urandom_range(0, 3)), $urandom);
            bus.out_ready  = ($urandom_range(0, 2) != 0);
            bus.flush      = ($urandom_range(0, 15) == 0);
            #1;
            chk("rnd hazard_stall", bus.hazard_stall, exp_hazard());
            chk("rnd in_ready", bus.in_ready, exp_ready());
            model_edge();
            nxt();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
